// File: rtl/timer_countdown_chain_if.sv
// Port bundle for the oven countdown timer: keypad/control strobes in, count and flags out.
// The master modport is the controller side, the slave modport is the timer itself.
interface timer_countdown_chain_if #(
   parameter int DIGITS = 4
);
   // Control inputs are plain one-cycle strobes with no ready path.
   // A strobe acts at the first rising edge that samples it high.
   // Outputs are registered and valid in every cycle after reset.
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  start;
   logic                  pause;
   logic                  tick;
   logic [4*DIGITS-1:0]   out;
   logic                  zero;
   logic                  done;
   logic                  running;
   logic [1:0]            state_dbg;

   modport master (
      output load, load_val, start, pause, tick,
      input  out, zero, done, running, state_dbg
   );

   modport slave (
      input  load, load_val, start, pause, tick,
      output out, zero, done, running, state_dbg
   );
endinterface

// File: rtl/timer_countdown_chain.sv
// Cascade of mixed-modulus BCD down-counter digits with a start/pause FSM (default MM:SS).
// Define TIMER_LOAD_CLAMP_EN to clamp each loaded digit to its modulus minus one.
module timer_countdown_chain #(
   parameter int                  DIGITS = 4,
   parameter logic [4*DIGITS-1:0] MODS   = 16'hAA6A
) (
   input  logic                   clk,
   input  logic                   rst,
   timer_countdown_chain_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int W = 4 * DIGITS;

   state_t         state_q, state_d;
   logic [W-1:0]   out_q, out_d;
   logic           zero_q, zero_d;
   logic           done_q, done_d;

   logic [W-1:0]   dec_val;
   logic [DIGITS:0] borrow;
   logic [W-1:0]   load_fixed;

`ifdef TIMER_LOAD_CLAMP_EN
   function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= MODS[4*i +: 4]) begin
            r[4*i +: 4] = MODS[4*i +: 4] - 4'd1;
         end
      end
      return r;
   endfunction

   always_comb begin
      load_fixed = clamp_load(bus.load_val);
   end
`else
   always_comb begin
      load_fixed = bus.load_val;
   end
`endif

   // Ripple borrow: a zero digit wraps to its modulus minus one and passes the borrow up.
   always_comb begin
      dec_val   = out_q;
      borrow    = '0;
      borrow[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow[i]) begin
            if (out_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = MODS[4*i +: 4] - 4'd1;
               borrow[i+1]       = 1'b1;
            end else begin
               dec_val[4*i +: 4] = out_q[4*i +: 4] - 4'd1;
               borrow[i+1]       = 1'b0;
            end
         end else begin
            dec_val[4*i +: 4] = out_q[4*i +: 4];
            borrow[i+1]       = 1'b0;
         end
      end
   end

   // Priority load > pause > start > tick; a strobe that is illegal in the
   // current state is treated as absent so lower-priority strobes still act.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      if (bus.load && (state_q != ST_RUN)) begin
         out_d   = load_fixed;
         zero_d  = (load_fixed == '0);
         state_d = ST_IDLE;
      end else if (bus.pause && (state_q == ST_RUN)) begin
         state_d = ST_PAUSED;
      end else if (bus.start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED))
                   && (out_q != '0)) begin
         state_d = ST_RUN;
      end else if (bus.tick && (state_q == ST_RUN)) begin
         out_d  = dec_val;
         zero_d = (dec_val == '0);
         if (dec_val == '0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         out_q   <= '0;
         zero_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.zero      = zero_q;
   assign bus.done      = done_q;
   assign bus.running   = (state_q == ST_RUN);
   assign bus.state_dbg = state_q;

endmodule
